// File: rtl/alu_mdu_pkg.sv
// alu_op_pkg: shared types for the multi-cycle ALU / M-extension unit.
//   alu_op_t        - operation select: base RV integer ops plus the M ops.
//   alu_mdu_state_t - FSM states of the alu_mdu control path.
//   is_muldiv/is_mul/is_div/is_rem - op classification helpers.
package alu_op_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_XOR    = 5'd2,
    OP_OR     = 5'd3,
    OP_AND    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } alu_mdu_state_t;

  function automatic logic is_mul(alu_op_t op);
    return (op >= OP_MUL) && (op <= OP_MULHU);
  endfunction

  function automatic logic is_div(alu_op_t op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

  function automatic logic is_muldiv(alu_op_t op);
    return is_mul(op) || is_div(op);
  endfunction

  function automatic logic is_rem(alu_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_mdu_div_iter.sv
// div_iter: unsigned restoring radix-2 divider, one quotient bit per cycle.
// Ports:
//   clk, rst_n (async active-low), flush (sync abort)
//   start             - load dividend/divisor magnitudes and begin
//   dividend, divisor - XLEN-bit unsigned magnitudes
//   done              - high during the final iteration cycle
//   quot, rem         - step results; final values when done is high
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);

  localparam int CW = $clog2(XLEN);

  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] dvs_q, dvs_d;

  logic [XLEN:0]   shifted;
  logic            ge;
  logic [XLEN-1:0] diff;
  logic            last;

  // Partial remainder stays below the divisor, so the shifted value needs
  // one extra bit and the difference (when taken) fits back into XLEN bits.
  assign shifted = {rem_q, quot_q[XLEN-1]};
  assign ge      = (shifted >= {1'b0, dvs_q});
  assign diff    = shifted[XLEN-1:0] - dvs_q;
  assign last    = (cnt_q == CW'(XLEN - 1));

  assign quot = {quot_q[XLEN-2:0], ge};
  assign rem  = ge ? diff : shifted[XLEN-1:0];
  assign done = busy_q && last;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quot_d = quot_q;
    dvs_d  = dvs_q;
    if (flush) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      quot_d = dividend;
      dvs_d  = divisor;
    end else if (busy_q) begin
      rem_d  = rem;
      quot_d = quot;
      cnt_d  = CW'(cnt_q + 1'b1);
      if (last) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvs_q  <= dvs_d;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: multi-cycle execute-stage ALU with RV M-extension support.
// One op in flight; valid/ready on both sides; synchronous flush.
// Ports:
//   clk, rst_n (async active-low), flush (sync abort of in-flight op)
//   in_valid/in_ready, op, a, b   - operation request
//   out_valid/out_ready           - result handshake
//   result, zero                  - registered result and result==0 flag
module alu_mdu
  import alu_op_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int MUL_STAGES     = 2,
  parameter int EARLY_DIV_ZERO = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SHW = $clog2(XLEN);
  localparam int PW  = 2 * XLEN;

  function automatic logic [XLEN-1:0] alu_base(alu_op_t f_op, logic [XLEN-1:0] x,
                                               logic [XLEN-1:0] y);
    logic [SHW-1:0] sh;
    sh = y[SHW-1:0];
    case (f_op)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_XOR:  return x ^ y;
      OP_OR:   return x | y;
      OP_AND:  return x & y;
      OP_SLL:  return x << sh;
      OP_SRL:  return x >> sh;
      OP_SRA:  return $signed(x) >>> sh;
      OP_SLT:  return XLEN'($signed(x) < $signed(y));
      OP_SLTU: return XLEN'(x < y);
      default: return '0;
    endcase
  endfunction

  alu_mdu_state_t  state_q, state_d;
  alu_op_t         op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            dz_q, dz_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [PW-1:0]   prod_q [MUL_STAGES];
  logic [PW-1:0]   prod_d [MUL_STAGES];
  logic            res_we;

  logic accept;
  assign accept = in_valid && (state_q == S_IDLE) && !flush;

  // Multiplier operands extended to 2*XLEN; the product modulo 2^(2*XLEN)
  // is exact for every signed/unsigned combination.
  logic          mul_sa, mul_sb;
  logic [PW-1:0] a_ext, b_ext, prod_full;
  assign mul_sa    = (op != OP_MULHU);
  assign mul_sb    = (op == OP_MUL) || (op == OP_MULH);
  assign a_ext     = {{XLEN{mul_sa & a[XLEN-1]}}, a};
  assign b_ext     = {{XLEN{mul_sb & b[XLEN-1]}}, b};
  assign prod_full = a_ext * b_ext;

  logic [XLEN-1:0] mul_res;
  assign mul_res = (op_q == OP_MUL) ? prod_q[MUL_STAGES-1][XLEN-1:0]
                                    : prod_q[MUL_STAGES-1][PW-1:XLEN];

  // Divider works on magnitudes; signs are restored on completion.
  logic            sdiv, a_neg, b_neg, b_zero, early_dz, div_start;
  logic [XLEN-1:0] dvd_mag, dvs_mag;
  assign sdiv      = (op == OP_DIV) || (op == OP_REM);
  assign a_neg     = sdiv & a[XLEN-1];
  assign b_neg     = sdiv & b[XLEN-1];
  assign dvd_mag   = a_neg ? -a : a;
  assign dvs_mag   = b_neg ? -b : b;
  assign b_zero    = (b == '0);
  assign early_dz  = (EARLY_DIV_ZERO != 0) && b_zero;
  assign div_start = accept && is_div(op) && !early_dz;

  logic            div_done;
  logic [XLEN-1:0] div_quot, div_rem;

  div_iter #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .start    (div_start),
    .dividend (dvd_mag),
    .divisor  (dvs_mag),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  // Most-negative / -1 falls out naturally: magnitude quotient 2^(XLEN-1)
  // with equal signs is left un-negated, which equals a; remainder is 0.
  logic [XLEN-1:0] q_fix, r_fix, div_res;
  assign q_fix   = qneg_q ? -div_quot : div_quot;
  assign r_fix   = rneg_q ? -div_rem : div_rem;
  assign div_res = dz_q ? (is_rem(op_q) ? a_q : '1)
                        : (is_rem(op_q) ? r_fix : q_fix);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    dz_d     = dz_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    res_we   = 1'b0;

    // Stage 0 captures the product at accept; later stages just shift.
    prod_d[0] = accept ? prod_full : prod_q[0];
    for (int i = 1; i < MUL_STAGES; i++) begin
      prod_d[i] = prod_q[i-1];
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = op;
          a_d    = a;
          dz_d   = b_zero;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          cnt_d  = '0;
          if (is_mul(op)) begin
            state_d = S_MUL;
          end else if (is_div(op)) begin
            if (early_dz) begin
              state_d  = S_DONE;
              result_d = is_rem(op) ? a : '1;
              res_we   = 1'b1;
            end else begin
              state_d = S_DIV;
            end
          end else begin
            state_d  = S_DONE;
            result_d = alu_base(op, a, b);
            res_we   = 1'b1;
          end
        end
      end
      S_MUL: begin
        cnt_d = 3'(cnt_q + 3'd1);
        if (cnt_q == 3'(MUL_STAGES - 1)) begin
          state_d  = S_DONE;
          result_d = mul_res;
          res_we   = 1'b1;
        end
      end
      S_DIV: begin
        if (div_done) begin
          state_d  = S_DONE;
          result_d = div_res;
          res_we   = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
      res_we   = 1'b0;
    end

    // zero only follows a newly written result so it stays 0 after reset.
    zero_d = res_we ? (result_d == '0) : zero_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      dz_q     <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= '0;
      for (int i = 0; i < MUL_STAGES; i++) begin
        prod_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      dz_q     <= dz_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      cnt_q    <= cnt_d;
      for (int i = 0; i < MUL_STAGES; i++) begin
        prod_q[i] <= prod_d[i];
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;

endmodule
